// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, next-PC selection and a RUN/HALT/ERROR sequencer.
// Optional performance counters are compiled in when PC_PERF_CNT_EN is defined.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] imm_shifted,
  input  logic [25:0] jump_index,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        halted,
  output logic        misalign_err
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] taken_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] next_sel;

  assign pc_plus4_w    = pc_q + 32'd4;
  assign branch_target = pc_plus4_w + imm_shifted;
  assign jump_target   = {pc_plus4_w[31:28], jump_index, 2'b00};

  // Jump outranks a taken branch; only the branch path can produce a misaligned target.
  always_comb begin
    next_sel = pc_plus4_w;
    if (jump) begin
      next_sel = jump_target;
    end else if (branch && zero) begin
      next_sel = branch_target;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    unique case (state_q)
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (stall) begin
          state_d = S_RUN;
        end else if (next_sel[1:0] != 2'b00) begin
          pc_d    = TRAP_PC;
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          pc_d = next_sel;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_d = S_RUN;
        end
      end
      S_ERROR: begin
        pc_d  = TRAP_PC;
        err_d = 1'b1;
      end
      default: begin
        // Unused encoding: park in the trap state rather than run from an unknown PC.
        state_d = S_ERROR;
        pc_d    = TRAP_PC;
        err_d   = 1'b1;
      end
    endcase
    halted_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_w;
  assign taken        = branch & zero & ~jump;
  assign halted       = halted_q;
  assign misalign_err = err_q;

`ifdef PC_PERF_CNT_EN
  logic [31:0] instr_cnt_q;
  logic [31:0] taken_cnt_q;
  logic        pc_update;

  // A retiring update: RUN, not halting, not stalled, and not the trap load.
  assign pc_update = (state_q == S_RUN) && !halt_req && !stall && (next_sel[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else if (pc_update) begin
      instr_cnt_q <= instr_cnt_q + 32'd1;
      if (taken && !jump) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign taken_cnt = taken_cnt_q;
`endif

endmodule
